mtpsa_egress_tuser_merge: RTL and testbench
===========================================

# mtpsa_egress_tuser_merge

Parametrised egress metadata merger between the SDNet egress pipeline and the SUME output datapath. It buffers the per-packet metadata tuple and digest tuple in independent FIFOs and aligns them to packet boundaries, tolerating tuple/digest arrival before, during or after the packet's first beat. It emits one merged TUSER per packet: the digest replaces the queue-size fields, over a registered AXIS output stage. It optionally filters packets whose user_id is out of range.

## Interface
- C_AXIS_DATA_WIDTH, 256, packet TDATA width (TKEEP = /8)
- C_S_TUSER_WIDTH, 128, metadata tuple width; bits [47:0] = pkt_len, src_port, dst_port, send_dig, user_id
- DIGEST_WIDTH, 256, digest tuple width
- C_M_AXIS_TUSER_WIDTH, 304, output TUSER width; must equal DIGEST_WIDTH+48
- FIFO_DEPTH, 4, entries per tuple FIFO; power of two, ≥2
- NUM_USERS, 8, valid user_id range 0..NUM_USERS-1
- axis_aclk  in  1  single clock
- axis_resetn  in  1  reset; asynchronous, active-low
- s_axis_tdata/tkeep/tvalid/tlast  in  per width  packet from SDNet
- s_axis_tready  out  1  packet backpressure
- s_tuple_valid  in  1  one-cycle strobe, metadata tuple
- s_tuple_data  in  C_S_TUSER_WIDTH  metadata tuple
- s_digest_valid  in  1  one-cycle strobe, digest tuple
- s_digest_data  in  DIGEST_WIDTH  digest tuple
- m_axis_tdata/tkeep/tuser/tvalid/tlast  out  per width  merged packet stream
- m_axis_tready  in  1  downstream backpressure
- overflow  out  1  sticky; a tuple or digest was lost to a full FIFO
- overflow_count  out  16  saturating count of lost tuples plus lost digests
- drop_count  out  16  saturating count of filtered packets (zero without filter)

## Operation
- Two sync FIFOs: TF (metadata) and DF (digest). Push on the respective strobe.
- A push to a full FIFO is discarded. It sets overflow and increments overflow_count, which saturates at 0xFFFF.
- A push and a pop in the same cycle on a full FIFO are both accepted.
- FSM states: WAIT, FWD, DROP.
- WAIT: s_axis_tready=0. Leave WAIT when TF and DF are both non-empty, s_axis_tvalid=1, and the output slot is free.
  - On leaving WAIT, pop TF and DF together and latch merged tuser = {DF head, TF head[47:0]}.
  - Go to FWD, or to DROP when filtered.
- FWD: s_axis_tready = output slot free. Beats pass with the latched tuser, which is held constant until tlast. On an accepted tlast beat, return to WAIT.
- DROP: s_axis_tready=1. Beats are consumed and not forwarded. On tlast, return to WAIT and increment drop_count (saturating).
- A single-beat packet (tlast on the first beat) is handled in the leave-WAIT cycle's successor with no extra bubble beyond WAIT.
- Output register slice: m_axis_* are registered. The slot is free when !m_axis_tvalid or m_axis_tready.
- Reset mid-packet: both FIFOs are flushed, the FSM goes to WAIT, and any in-flight beat is lost. Upstream must also be reset.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata/tkeep/tuser=0, s_axis_tready=0, overflow=0, both counters 0, FIFOs empty, FSM in WAIT.
- Latency with tuples already buffered:
  - first s beat in WAIT → first m beat valid 2 cycles later (1 WAIT decision + 1 register).
  - subsequent beats: 1 cycle.
- Throughput: 1 beat/cycle inside a packet; 1 idle cycle between packets (WAIT).
- A tuple strobe is visible as FIFO non-empty on the cycle after the strobe.
- AXIS rules: m_axis_tvalid, once high, stays high with stable data until m_axis_tready=1. s_axis_tdata is sampled only when tvalid&tready.

## Configuration
- MTPSA_USER_FILTER_EN defined: a packet whose TF-head user_id ≥ NUM_USERS enters DROP. Its tuple and digest are still popped.
- MTPSA_USER_FILTER_EN undefined: DROP is unreachable, every packet is forwarded, and drop_count is tied to 0.

## Structure
- Package mtpsa_tuser_pkg holds:
  - field offsets (PKT_LEN_LSB=0, SRC_PORT_LSB=16, DST_PORT_LSB=24, SEND_DIG_LSB=32, USER_ID_LSB=40, META_KEEP_W=48);
  - the FSM state enum;
  - the saturating counter width (16).
- Sub-module mtpsa_tuple_fifo (WIDTH, DEPTH): async-reset sync FIFO with full/empty and a registered head. It is instantiated twice, for TF and DF.

## Test plan
- Tuple+digest strobed 3 cycles before a 4-beat packet, m_axis_tready=1:
  - 4 beats out, first m beat 2 cycles after the first s beat;
  - tuser = {digest, tuple[47:0]} constant on all beats.
- Packet first beat arrives 5 cycles before its tuples:
  - s_axis_tready=0 until both FIFOs are non-empty;
  - then data flows unchanged;
  - no overflow.
- 5 tuple strobes with FIFO_DEPTH=4 and no packets → overflow=1, overflow_count=1. Then 4 packets emerge with tuples 1-4 in order.
- m_axis_tready toggled 1/0 every cycle over a 3-beat packet:
  - tdata/tuser stable while stalled;
  - no beat lost or duplicated;
  - tlast only on beat 3.
- MTPSA_USER_FILTER_EN, NUM_USERS=8, user_id=9 on a 2-beat packet then user_id=2 on a 1-beat packet:
  - first packet consumed with no m beats;
  - drop_count=1;
  - second packet forwarded.
- axis_resetn pulsed low mid-packet with 2 tuples buffered:
  - all outputs return to reset values asynchronously;
  - FIFOs empty, counters 0;
  - next packet waits for fresh tuples.

Source files
------------

// File: rtl/mtpsa_tuser_pkg.sv
// Shared field offsets, FSM state encodings and counter helpers for the egress TUSER merger.
package mtpsa_tuser_pkg;

  localparam int unsigned PKT_LEN_LSB  = 0;
  localparam int unsigned SRC_PORT_LSB = 16;
  localparam int unsigned DST_PORT_LSB = 24;
  localparam int unsigned SEND_DIG_LSB = 32;
  localparam int unsigned USER_ID_LSB  = 40;
  localparam int unsigned USER_ID_W    = 8;
  localparam int unsigned META_KEEP_W  = 48;
  localparam int unsigned CNT_W        = 16;

  typedef logic [1:0] state_t;
  localparam state_t ST_WAIT = 2'd0;
  localparam state_t ST_FWD  = 2'd1;
  localparam state_t ST_DROP = 2'd2;

  // Saturating add of a small increment (0..3) to a status counter.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + (CNT_W+1)'(inc);
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/mtpsa_egress_tuser_merge_fifo.sv
// Sync tuple FIFO with registered head; a push into a full FIFO is dropped unless a pop frees a slot.
module mtpsa_tuple_fifo #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             lost_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_next;
  logic [AW:0]      count;
  logic             do_pop;
  logic             do_push;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign lost_c  = push && full && !do_pop;
  assign rd_next = rd_ptr + AW'(1);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_next;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Head tracks the oldest entry; a lone entry popped alongside a push hands over to the new data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
    end else if (do_pop) begin
      head <= (count > (AW+1)'(1)) ? mem[rd_next] : push_data;
    end else if (empty && do_push) begin
      head <= push_data;
    end
  end

endmodule

// File: rtl/mtpsa_egress_tuser_merge.sv
// Merges buffered metadata/digest tuples into per-packet TUSER on a registered AXIS stage.
// Optional user_id range filter enabled by defining MTPSA_USER_FILTER_EN.
module mtpsa_egress_tuser_merge
  import mtpsa_tuser_pkg::*;
#(
  parameter int unsigned C_AXIS_DATA_WIDTH    = 256,
  parameter int unsigned C_S_TUSER_WIDTH      = 128,
  parameter int unsigned DIGEST_WIDTH         = 256,
  parameter int unsigned C_M_AXIS_TUSER_WIDTH = 304,
  parameter int unsigned FIFO_DEPTH           = 4,
  parameter int unsigned NUM_USERS            = 8
) (
  input  logic                            axis_aclk,
  input  logic                            axis_resetn,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  input  logic                            s_tuple_valid,
  input  logic [C_S_TUSER_WIDTH-1:0]      s_tuple_data,
  input  logic                            s_digest_valid,
  input  logic [DIGEST_WIDTH-1:0]         s_digest_data,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0] m_axis_tuser,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  output logic                            overflow,
  output logic [CNT_W-1:0]                overflow_count,
  output logic [CNT_W-1:0]                drop_count
);

`ifdef MTPSA_USER_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif

  state_t                          state;
  state_t                          state_nxt;
  logic [C_S_TUSER_WIDTH-1:0]      tf_head;
  logic [DIGEST_WIDTH-1:0]         df_head;
  logic                            tf_full, tf_empty, tf_lost_c;
  logic                            df_full, df_empty, df_lost_c;
  logic                            pop_c;
  logic                            slot_free_c;
  logic                            fwd_beat_c;
  logic                            drop_done_c;
  logic                            filtered_c;
  logic [USER_ID_W-1:0]            user_id_c;
  logic [C_M_AXIS_TUSER_WIDTH-1:0] tuser_q;
  logic [CNT_W-1:0]                drop_q;
  logic                            unused_full;
  logic                            unused_meta;

  mtpsa_tuple_fifo #(.WIDTH(C_S_TUSER_WIDTH), .DEPTH(FIFO_DEPTH)) u_tf (
    .clk(axis_aclk), .rst_n(axis_resetn),
    .push(s_tuple_valid), .push_data(s_tuple_data), .pop(pop_c),
    .head(tf_head), .full(tf_full), .empty(tf_empty), .lost_c(tf_lost_c)
  );

  mtpsa_tuple_fifo #(.WIDTH(DIGEST_WIDTH), .DEPTH(FIFO_DEPTH)) u_df (
    .clk(axis_aclk), .rst_n(axis_resetn),
    .push(s_digest_valid), .push_data(s_digest_data), .pop(pop_c),
    .head(df_head), .full(df_full), .empty(df_empty), .lost_c(df_lost_c)
  );

  assign unused_full = tf_full ^ df_full;
  assign unused_meta = ^tf_head[C_S_TUSER_WIDTH-1:META_KEEP_W];

  assign slot_free_c = !m_axis_tvalid || m_axis_tready;
  assign user_id_c   = tf_head[USER_ID_LSB +: USER_ID_W];
  assign filtered_c  = FILTER_EN && (32'(user_id_c) >= NUM_USERS);

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) state <= ST_WAIT;
    else              state <= state_nxt;
  end

  // Packet alignment: hold the first beat in WAIT until both tuples are buffered.
  always_comb begin
    state_nxt     = state;
    pop_c         = 1'b0;
    s_axis_tready = 1'b0;
    case (state)
      ST_WAIT: begin
        if (!tf_empty && !df_empty && s_axis_tvalid && slot_free_c) begin
          pop_c     = 1'b1;
          state_nxt = filtered_c ? ST_DROP : ST_FWD;
        end
      end
      ST_FWD: begin
        s_axis_tready = slot_free_c;
        if (s_axis_tvalid && slot_free_c && s_axis_tlast) state_nxt = ST_WAIT;
      end
      ST_DROP: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) state_nxt = ST_WAIT;
      end
      default: state_nxt = ST_WAIT;
    endcase
  end

  assign fwd_beat_c  = (state == ST_FWD) && s_axis_tvalid && slot_free_c;
  assign drop_done_c = (state == ST_DROP) && s_axis_tvalid && s_axis_tlast;

  // Digest takes the place of the queue-size fields above the kept metadata.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) tuser_q <= '0;
    else if (pop_c)   tuser_q <= {df_head, tf_head[META_KEEP_W-1:0]};
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= '0;
    end else if (slot_free_c) begin
      m_axis_tvalid <= fwd_beat_c;
      if (fwd_beat_c) begin
        m_axis_tdata <= s_axis_tdata;
        m_axis_tkeep <= s_axis_tkeep;
        m_axis_tlast <= s_axis_tlast;
        m_axis_tuser <= tuser_q;
      end
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      overflow       <= 1'b0;
      overflow_count <= '0;
      drop_q         <= '0;
    end else begin
      overflow       <= overflow | tf_lost_c | df_lost_c;
      overflow_count <= sat_add(overflow_count, 2'(tf_lost_c) + 2'(df_lost_c));
      drop_q         <= sat_add(drop_q, {1'b0, drop_done_c});
    end
  end

  assign drop_count = FILTER_EN ? drop_q : '0;

endmodule

// File: tb/tb_mtpsa_egress_tuser_merge.sv
// Directed bench for mtpsa_egress_tuser_merge; honours MTPSA_USER_FILTER_EN for the filter case.
module tb_mtpsa_egress_tuser_merge;

  localparam int unsigned DW = 256;
  localparam int unsigned KW = DW / 8;
  localparam int unsigned TW = 128;
  localparam int unsigned GW = 256;
  localparam int unsigned UW = 304;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [KW-1:0] s_axis_tkeep = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic          s_tuple_valid = 1'b0;
  logic [TW-1:0] s_tuple_data = '0;
  logic          s_digest_valid = 1'b0;
  logic [GW-1:0] s_digest_data = '0;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [UW-1:0] m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready = 1'b1;
  logic          overflow;
  logic [15:0]   overflow_count;
  logic [15:0]   drop_count;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t_first  = 0;

  logic [DW-1:0] cap_data[$];
  logic [UW-1:0] cap_user[$];
  logic          cap_last[$];
  int            cap_cyc[$];

  bit            toggle_en  = 1'b0;
  bit            chk_stall  = 1'b0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;
  logic [UW-1:0] prev_user  = '0;

  mtpsa_egress_tuser_merge #(
    .C_AXIS_DATA_WIDTH(DW), .C_S_TUSER_WIDTH(TW), .DIGEST_WIDTH(GW),
    .C_M_AXIS_TUSER_WIDTH(UW), .FIFO_DEPTH(4), .NUM_USERS(8)
  ) dut (
    .axis_aclk(clk), .axis_resetn(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .s_tuple_valid(s_tuple_valid), .s_tuple_data(s_tuple_data),
    .s_digest_valid(s_digest_valid), .s_digest_data(s_digest_data),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .overflow(overflow), .overflow_count(overflow_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [UW-1:0] obs, input logic [UW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [TW-1:0] mk_tup(input int i, input logic [7:0] uid);
    return {64'hDEAD_BEEF_0000_0000 | 64'(i), 16'h5A5A, uid, 8'(i), 8'(i + 1), 8'(i + 2), 16'(64 * i)};
  endfunction

  function automatic logic [GW-1:0] mk_dig(input int i);
    return {8{32'hC0DE_0000 + 32'(i)}};
  endfunction

  function automatic logic [UW-1:0] exp_user(input int i, input logic [7:0] uid);
    logic [TW-1:0] t;
    t = mk_tup(i, uid);
    return {mk_dig(i), t[47:0]};
  endfunction

  // Advance to the next falling edge: check stall stability, toggle backpressure, capture output beats.
  task automatic tick();
    @(negedge clk);
    if (chk_stall && prev_stall) begin
      chk("stall_valid", UW'(m_axis_tvalid), UW'(1'b1));
      chk("stall_data", UW'(m_axis_tdata), UW'(prev_data));
      chk("stall_user", m_axis_tuser, prev_user);
    end
    if (toggle_en) m_axis_tready = ~m_axis_tready;
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_data  = m_axis_tdata;
    prev_user  = m_axis_tuser;
    if (rst_n && m_axis_tvalid && m_axis_tready) begin
      cap_data.push_back(m_axis_tdata);
      cap_user.push_back(m_axis_tuser);
      cap_last.push_back(m_axis_tlast);
      cap_cyc.push_back(cyc);
    end
  endtask

  task automatic strobe(input bit t, input bit d, input int i, input logic [7:0] uid);
    s_tuple_valid  = t;
    s_tuple_data   = mk_tup(i, uid);
    s_digest_valid = d;
    s_digest_data  = mk_dig(i);
    tick();
    s_tuple_valid  = 1'b0;
    s_digest_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] data, input bit last);
    bit taken;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = data;
    s_axis_tkeep  = '1;
    s_axis_tlast  = last;
    taken = 1'b0;
    for (int n = 0; n < 64 && !taken; n++) begin
      #1;
      taken = s_axis_tready;
      tick();
    end
    chk("beat_accepted", UW'(taken), UW'(1'b1));
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_pkt(input int beats, input int base);
    t_first = cyc;
    for (int b = 0; b < beats; b++) send_beat(DW'(base + b), (b == beats - 1));
  endtask

  task automatic clear_cap();
    cap_data.delete();
    cap_user.delete();
    cap_last.delete();
    cap_cyc.delete();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    // Reset values
    #1;
    chk("rst_m_tvalid", UW'(m_axis_tvalid), '0);
    chk("rst_m_tlast", UW'(m_axis_tlast), '0);
    chk("rst_m_tuser", m_axis_tuser, '0);
    chk("rst_s_tready", UW'(s_axis_tready), '0);
    chk("rst_ovf_cnt", UW'(overflow_count), '0);
    tick();
    rst_n = 1'b1;
    idle(2);

    // 1: tuples three cycles ahead of a 4-beat packet
    strobe(1'b1, 1'b1, 1, 8'd1);
    idle(2);
    clear_cap();
    send_pkt(4, 'h100);
    idle(5);
    chk("t1_beats", UW'(cap_data.size()), UW'(4));
    if (cap_data.size() == 4) begin
      chk("t1_latency", UW'(cap_cyc[0] - t_first), UW'(2));
      for (int b = 0; b < 4; b++) begin
        chk("t1_data", UW'(cap_data[b]), UW'(DW'('h100 + b)));
        chk("t1_user", cap_user[b], exp_user(1, 8'd1));
        chk("t1_last", UW'(cap_last[b]), UW'(b == 3));
      end
    end

    // 2: first beat waits five cycles for its tuples
    clear_cap();
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = DW'('h200);
    s_axis_tkeep  = '1;
    s_axis_tlast  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t2_tready_low", UW'(s_axis_tready), '0);
      tick();
    end
    strobe(1'b1, 1'b1, 2, 8'd3);
    send_pkt(2, 'h200);
    idle(5);
    chk("t2_beats", UW'(cap_data.size()), UW'(2));
    if (cap_data.size() == 2) begin
      chk("t2_data0", UW'(cap_data[0]), UW'(DW'('h200)));
      chk("t2_data1", UW'(cap_data[1]), UW'(DW'('h201)));
      chk("t2_user", cap_user[1], exp_user(2, 8'd3));
    end
    chk("t2_no_ovf", UW'(overflow), '0);

    // 3: five tuples into a depth-4 FIFO, then four packets drain in order
    for (int i = 11; i <= 15; i++) strobe(1'b1, 1'b0, i, 8'd1);
    chk("t3_overflow", UW'(overflow), UW'(1'b1));
    chk("t3_ovf_cnt", UW'(overflow_count), UW'(16'd1));
    for (int i = 11; i <= 14; i++) strobe(1'b0, 1'b1, i, 8'd1);
    clear_cap();
    for (int p = 0; p < 4; p++) send_pkt(1, 'h300 + p);
    idle(5);
    chk("t3_beats", UW'(cap_data.size()), UW'(4));
    if (cap_data.size() == 4) begin
      for (int p = 0; p < 4; p++) begin
        chk("t3_user", cap_user[p], exp_user(11 + p, 8'd1));
        chk("t3_data", UW'(cap_data[p]), UW'(DW'('h300 + p)));
      end
    end
    chk("t3_ovf_cnt_hold", UW'(overflow_count), UW'(16'd1));

    // 4: downstream ready toggling every cycle
    strobe(1'b1, 1'b1, 20, 8'd4);
    clear_cap();
    toggle_en = 1'b1;
    chk_stall = 1'b1;
    send_pkt(3, 'h400);
    idle(8);
    toggle_en     = 1'b0;
    chk_stall     = 1'b0;
    m_axis_tready = 1'b1;
    idle(3);
    chk("t4_beats", UW'(cap_data.size()), UW'(3));
    if (cap_data.size() == 3) begin
      for (int b = 0; b < 3; b++) begin
        chk("t4_data", UW'(cap_data[b]), UW'(DW'('h400 + b)));
        chk("t4_user", cap_user[b], exp_user(20, 8'd4));
        chk("t4_last", UW'(cap_last[b]), UW'(b == 2));
      end
    end

    // 5: user_id filter (out-of-range user then in-range user)
    strobe(1'b1, 1'b1, 21, 8'd9);
    strobe(1'b1, 1'b1, 22, 8'd2);
    clear_cap();
    send_pkt(2, 'h500);
    send_pkt(1, 'h600);
    idle(5);
`ifdef MTPSA_USER_FILTER_EN
    chk("t5_beats", UW'(cap_data.size()), UW'(1));
    chk("t5_drop_cnt", UW'(drop_count), UW'(16'd1));
    if (cap_data.size() == 1) begin
      chk("t5_data", UW'(cap_data[0]), UW'(DW'('h600)));
      chk("t5_user", cap_user[0], exp_user(22, 8'd2));
    end
`else
    chk("t5_beats", UW'(cap_data.size()), UW'(3));
    chk("t5_drop_cnt", UW'(drop_count), '0);
    if (cap_data.size() == 3) begin
      chk("t5_user_hi", cap_user[0], exp_user(21, 8'd9));
      chk("t5_data", UW'(cap_data[2]), UW'(DW'('h600)));
      chk("t5_user", cap_user[2], exp_user(22, 8'd2));
    end
`endif

    // 6: asynchronous reset mid-packet with two tuples buffered
    strobe(1'b1, 1'b1, 30, 8'd1);
    strobe(1'b1, 1'b1, 31, 8'd1);
    clear_cap();
    m_axis_tready = 1'b0;
    send_beat(DW'('h700), 1'b0);
    chk("t6_pre_valid", UW'(m_axis_tvalid), UW'(1'b1));
    chk("t6_pre_keep", UW'(m_axis_tkeep), UW'({KW{1'b1}}));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_m_tvalid", UW'(m_axis_tvalid), '0);
    chk("t6_m_tlast", UW'(m_axis_tlast), '0);
    chk("t6_m_tdata", UW'(m_axis_tdata), '0);
    chk("t6_m_tkeep", UW'(m_axis_tkeep), '0);
    chk("t6_m_tuser", m_axis_tuser, '0);
    chk("t6_overflow", UW'(overflow), '0);
    chk("t6_ovf_cnt", UW'(overflow_count), '0);
    chk("t6_drop_cnt", UW'(drop_count), '0);
    tick();
    rst_n         = 1'b1;
    m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = DW'('h800);
    s_axis_tkeep  = '1;
    s_axis_tlast  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t6_wait_fresh", UW'(s_axis_tready), '0);
      tick();
    end
    strobe(1'b1, 1'b1, 32, 8'd5);
    send_pkt(2, 'h800);
    idle(5);
    chk("t6_beats", UW'(cap_data.size()), UW'(2));
    if (cap_data.size() == 2) begin
      chk("t6_user", cap_user[0], exp_user(32, 8'd5));
      chk("t6_data", UW'(cap_data[1]), UW'(DW'('h801)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
